// File: rtl/div_seq.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle, holding the pipeline
// stalled until {remainder, quotient} is ready for the HI/LO write.
module div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StDivZero,
    StOn,
    StEnd
  } state_e;

  state_e             r_state, w_state_d;
  logic [CntW-1:0]    r_cnt, w_cnt_d;
  logic [WIDTH-1:0]   r_rem, w_rem_d;
  logic [WIDTH-1:0]   r_quo, w_quo_d;
  logic [WIDTH-1:0]   r_dvs, w_dvs_d;
  logic               r_neg_q, w_neg_q_d;
  logic               r_neg_r, w_neg_r_d;
  logic [2*WIDTH-1:0] r_result, w_result_d;

  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_fits;
  logic [WIDTH-1:0]   w_rem_step;
  logic [WIDTH-1:0]   w_quo_step;
  logic [WIDTH-1:0]   w_rem_fin;
  logic [WIDTH-1:0]   w_quo_fin;
  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;

  // One restoring step: shift the next dividend bit in, keep the difference if it did not borrow.
  always_comb begin
    w_shift    = {r_rem, r_quo[WIDTH-1]};
    w_diff     = w_shift - {1'b0, r_dvs};
    w_fits     = ~w_diff[WIDTH];
    w_rem_step = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_quo_step = {r_quo[WIDTH-2:0], w_fits};
    w_quo_fin  = r_neg_q ? -w_quo_step : w_quo_step;
    w_rem_fin  = r_neg_r ? -w_rem_step : w_rem_step;
    w_abs1     = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    w_abs2     = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
  end

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_rem_d    = r_rem;
    w_quo_d    = r_quo;
    w_dvs_d    = r_dvs;
    w_neg_q_d  = r_neg_q;
    w_neg_r_d  = r_neg_r;
    w_result_d = r_result;

    unique case (r_state)
      StIdle: begin
        if (start && !annul) begin
          w_neg_q_d = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
          w_neg_r_d = signed_div & opdata1[WIDTH-1];
          w_quo_d   = w_abs1;
          w_dvs_d   = w_abs2;
          w_cnt_d   = '0;
          if (opdata2 == '0) begin
            // Raw dividend parked in r_rem; it becomes the remainder of a divide by zero.
            w_rem_d   = opdata1;
            w_state_d = StDivZero;
          end else begin
            w_rem_d   = '0;
            w_state_d = StOn;
          end
        end
      end
      StOn: begin
        if (annul) begin
          w_state_d = StIdle;
        end else begin
          w_rem_d = w_rem_step;
          w_quo_d = w_quo_step;
          w_cnt_d = r_cnt + CntW'(1);
          if (r_cnt == CntW'(WIDTH - 1)) begin
            w_result_d = {w_rem_fin, w_quo_fin};
            w_state_d  = StEnd;
          end
        end
      end
      StDivZero: begin
        if (annul) begin
          w_state_d = StIdle;
        end else begin
          w_result_d = {r_rem, {WIDTH{1'b1}}};
          w_state_d  = StEnd;
        end
      end
      StEnd: begin
        if (annul || !start) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_rem    <= w_rem_d;
      r_quo    <= w_quo_d;
      r_dvs    <= w_dvs_d;
      r_neg_q  <= w_neg_q_d;
      r_neg_r  <= w_neg_r_d;
      r_result <= w_result_d;
    end
  end

  assign result = r_result;
  assign ready  = (r_state == StEnd);
  assign stall  = start & ~ready & ~annul;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: expected results are queued when an operation is driven and
// compared when ready rises.
module tb_div_seq;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stall;

  int          errors;
  int          checks;
  logic [63:0] sb_q[$];
  logic [63:0] last_res;

  div_seq #(.WIDTH(32)) u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .signed_div(signed_div),
    .opdata1   (opdata1),
    .opdata2   (opdata2),
    .annul     (annul),
    .result    (result),
    .ready     (ready),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa, sd, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sd = b;
    q  = sa / sd;
    r  = sa % sd;
    return {r, q};
  endfunction

  // Drives one operation with start held, waits for ready, then drops start.
  task automatic do_op(input string tag, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input int hold, input bit scramble);
    logic [63:0] exp;
    int          cyc;
    bit          stall_ok;
    @(posedge clk);
    #1;
    start      = 1'b1;
    signed_div = s;
    opdata1    = a;
    opdata2    = b;
    sb_q.push_back(model(s, a, b));
    cyc      = 0;
    stall_ok = 1'b1;
    @(negedge clk);
    while (!ready && cyc < 100) begin
      if (!stall) stall_ok = 1'b0;
      @(posedge clk);
      cyc++;
      if (scramble && cyc == 5) begin
        #1;
        opdata1    = 32'h1357_9BDF;
        opdata2    = 32'h0000_0003;
        signed_div = ~s;
      end
      @(negedge clk);
    end
    exp = sb_q.pop_front();
    chk({tag, "_latency"}, 64'(cyc), 64'(lat));
    chk({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
    chk({tag, "_ready"}, 64'(ready), 64'd1);
    chk({tag, "_result"}, result, exp);
    chk({tag, "_stall_done"}, 64'(stall), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold_ready"}, 64'(ready), 64'd1);
      chk({tag, "_hold_result"}, result, exp);
    end
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_idle_ready"}, 64'(ready), 64'd0);
    chk({tag, "_idle_result"}, result, exp);
    last_res = exp;
  endtask

  initial begin
    bit quiet;
    errors     = 0;
    checks     = 0;
    resetn     = 1'b0;
    start      = 1'b0;
    signed_div = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    annul      = 1'b0;
    last_res   = '0;
    #1;
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    #21;
    resetn = 1'b1;

    do_op("divu_100_7", 1'b0, 32'd100, 32'd7, 33, 0, 1'b0);
    chk("divu_100_7_const", last_res, {32'd2, 32'd14});
    do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 0, 1'b0);
    chk("div_m7_2_const", last_res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op("divu_fff9_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 33, 0, 1'b0);
    chk("divu_fff9_2_const", last_res, {32'd1, 32'h7FFF_FFFC});
    do_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 0, 1'b0);
    do_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 0, 1'b0);
    do_op("divu_by0", 1'b0, 32'd5, 32'd0, 2, 0, 1'b0);
    do_op("div_by0", 1'b1, 32'hFFFF_FFF7, 32'd0, 2, 0, 1'b0);
    do_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, 0, 1'b0);

    // start together with annul in IDLE must not be accepted.
    @(posedge clk);
    #1;
    start   = 1'b1;
    annul   = 1'b1;
    opdata1 = 32'd50;
    opdata2 = 32'd5;
    quiet   = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (ready || stall) quiet = 1'b0;
    end
    chk("idle_annul_quiet", 64'(quiet), 64'd1);
    start = 1'b0;
    annul = 1'b0;

    // Annul in the 10th ON cycle.
    @(posedge clk);
    #1;
    start   = 1'b1;
    opdata1 = 32'd1000;
    opdata2 = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("annul_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    annul = 1'b0;
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (ready) quiet = 1'b0;
    end
    chk("annul_no_ready", 64'(quiet), 64'd1);
    chk("annul_result_kept", result, last_res);
    do_op("divu_200_10", 1'b0, 32'd200, 32'd10, 33, 0, 1'b0);

    // Asynchronous reset mid-operation.
    @(posedge clk);
    #1;
    start   = 1'b1;
    opdata1 = 32'd1000;
    opdata2 = 32'd3;
    repeat (6) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("async_rst_ready", 64'(ready), 64'd0);
    chk("async_rst_result", result, 64'd0);
    start = 1'b0;
    @(posedge clk);
    #3;
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(ready), 64'd0);
    do_op("divu_9_3", 1'b0, 32'd9, 32'd3, 33, 0, 1'b0);

    do_op("divu_hold_scr", 1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 33, 3, 1'b1);
    do_op("div_hold_scr", 1'b1, 32'h8765_4321, 32'h0000_0123, 33, 3, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
